// File: rtl/regfile_alu_pkg.sv
// Shared types and default widths for the RegFile_Alu control sequencer.
`default_nettype none

package regfile_alu_pkg;

  localparam int OP_W   = 5;
  localparam int RA_W   = 4;
  localparam int DATA_W = 16;
  localparam int FLAG_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Field order matches the FIFO word layout used by the controller.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic              imm_s;
    logic [RA_W-1:0]   rdest;
    logic [RA_W-1:0]   rsrc;
    logic [DATA_W-1:0] imm;
  } cmd_t;

endpackage

`default_nettype wire

// File: rtl/regfile_alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count and registered full/empty flags.
`default_nettype none

module regfile_alu_cmd_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Flags are registered from the next count so they never depend on this cycle's inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_alu_ctrl.sv
// Clocked sequencer driving the RegFile_Alu control inputs: buffered command issue,
// single-cycle write enables, result capture and register-file clear sequencing.
`default_nettype none

module regfile_alu_ctrl #(
  parameter int OP_W       = regfile_alu_pkg::OP_W,
  parameter int RA_W       = regfile_alu_pkg::RA_W,
  parameter int DATA_W     = regfile_alu_pkg::DATA_W,
  parameter int FLAG_W     = regfile_alu_pkg::FLAG_W,
  parameter int DEPTH      = 4,
  parameter int CLR_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   Rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OP_W-1:0]        cmd_op,
  input  logic                   cmd_imm_s,
  input  logic [RA_W-1:0]        cmd_rdest,
  input  logic [RA_W-1:0]        cmd_rsrc,
  input  logic [DATA_W-1:0]      cmd_imm,
  input  logic                   clr_req,
  output logic [OP_W-1:0]        dp_OpCode,
  output logic                   dp_Imm_s,
  output logic [RA_W-1:0]        dp_RdestLoc,
  output logic [RA_W-1:0]        dp_RsrcLoc,
  output logic [DATA_W-1:0]      dp_Imm,
  output logic                   dp_En,
  output logic                   dp_Rst,
  input  logic [DATA_W-1:0]      dp_AluOutput,
  input  logic [FLAG_W-1:0]      dp_Flags,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_W-1:0]      res_data,
  output logic [FLAG_W-1:0]      res_flags,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  import regfile_alu_pkg::*;

  localparam int CMD_W = OP_W + 1 + 2 * RA_W + DATA_W;
  localparam int CLR_W = $clog2(CLR_CYCLES) + 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic             clr_pend;
  logic [CLR_W-1:0] clr_cnt;
  logic [CMD_W-1:0] fifo_wdata;
  logic [CMD_W-1:0] fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign fifo_wdata = {cmd_op, cmd_imm_s, cmd_rdest, cmd_rsrc, cmd_imm};
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign busy       = (state != IDLE) || !fifo_empty || clr_pend;

  regfile_alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (Rst),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A result being accepted this edge counts as a free result slot, so pops chain without a bubble.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (clr_pend) begin
          state_nxt = CLEAR;
        end else if (!fifo_empty && (!res_valid || res_ready)) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = IDLE;
      CLEAR:   if (clr_cnt == CLR_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rst aborts an in-flight issue at once, so the enable is masked while it is high.
  assign dp_En  = (state == ISSUE) && !Rst;
  assign dp_Rst = Rst || (state == CLEAR);

  always_ff @(posedge clk) begin
    if (Rst) begin
      state       <= IDLE;
      clr_pend    <= 1'b0;
      clr_cnt     <= '0;
      dp_OpCode   <= '0;
      dp_Imm_s    <= 1'b0;
      dp_RdestLoc <= '0;
      dp_RsrcLoc  <= '0;
      dp_Imm      <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_flags   <= '0;
    end else begin
      state <= state_nxt;

      // Requests arriving while a clear is pending or running merge into that clear.
      if (state == IDLE && clr_pend) begin
        clr_pend <= 1'b0;
      end else if (clr_req && state != CLEAR) begin
        clr_pend <= 1'b1;
      end

      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      else                clr_cnt <= '0;

      if (pop) begin
        {dp_OpCode, dp_Imm_s, dp_RdestLoc, dp_RsrcLoc, dp_Imm} <= fifo_rdata;
      end

      if (state == ISSUE) begin
        res_data  <= dp_AluOutput;
        res_flags <= dp_Flags;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
